// File: rtl/rv_muldiv_unit.sv
// RV32M/RV64M multiply/divide unit: one operation at a time, radix-2 iterative divider,
// single-cycle or iterative multiplier selected by FAST_MUL.
module rv_muldiv_unit #(
  parameter int XLEN     = 32,
  parameter bit FAST_MUL = 1'b1
) (
  input  logic            clk_i,
  input  logic            arstn_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [2:0]      req_op_i,
  input  logic [XLEN-1:0] req_rs1_i,
  input  logic [XLEN-1:0] req_rs2_i,
  input  logic            flush_i,
  output logic            resp_valid_o,
  input  logic            resp_ready_i,
  output logic [XLEN-1:0] resp_result_o,
  output logic [1:0]      dbg_state_o
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both high;
  // valid never waits on ready, and resp_result_o holds while resp_valid_o & !resp_ready_i.
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_DONE = 2'd2} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic [XLEN-1:0] rs1_q, rs1_d, rs2_q, rs2_d;
  logic [XLEN-1:0] acc_q, acc_d, quo_q, quo_d, dvs_q, dvs_d;
  logic            neg_q, neg_d, negr_q, negr_d;
  logic            resp_valid_q, resp_valid_d;
  logic [XLEN-1:0] result_q, result_d;

  logic              in_a_neg, in_b_neg;
  logic [XLEN-1:0]   in_a_mag, in_b_mag;
  logic [XLEN:0]     mul_sum, div_shift;
  logic [XLEN-1:0]   step_acc, step_quo;
  logic [2*XLEN-1:0] prod_mag, prod_it, fast_prod;
  logic [XLEN-1:0]   quot, remv, iter_res, fast_res, res_sel;
  logic              fa_sbit, fb_sbit;

  function automatic logic a_signed(input logic [2:0] op);
    return op[2] ? !op[0] : (op[1:0] != 2'b11);
  endfunction

  function automatic logic b_signed(input logic [2:0] op);
    return op[2] ? !op[0] : !op[1];
  endfunction

  function automatic logic is_special(input logic [2:0] op, input logic [XLEN-1:0] a,
                                      input logic [XLEN-1:0] b);
    return op[2] & ((b == '0) |
           (!op[0] & (a == {1'b1, {(XLEN-1){1'b0}}}) & (b == '1)));
  endfunction

  function automatic logic [XLEN-1:0] special_val(input logic [2:0] op, input logic [XLEN-1:0] a,
                                                  input logic [XLEN-1:0] b);
    if (b == '0) return op[1] ? a : '1;
    return op[1] ? '0 : a;
  endfunction

  // Datapath: magnitudes in, one shift-add / shift-subtract step per CALC cycle, sign fix-up out.
  always_comb begin
    in_a_neg = a_signed(req_op_i) & req_rs1_i[XLEN-1];
    in_b_neg = b_signed(req_op_i) & req_rs2_i[XLEN-1];
    in_a_mag = in_a_neg ? -req_rs1_i : req_rs1_i;
    in_b_mag = in_b_neg ? -req_rs2_i : req_rs2_i;

    mul_sum   = {1'b0, acc_q} + (quo_q[0] ? {1'b0, dvs_q} : '0);
    div_shift = {acc_q, quo_q[XLEN-1]};
    if (op_q[2]) begin
      if (div_shift >= {1'b0, dvs_q}) begin
        step_acc = div_shift[XLEN-1:0] - dvs_q;
        step_quo = {quo_q[XLEN-2:0], 1'b1};
      end else begin
        step_acc = div_shift[XLEN-1:0];
        step_quo = {quo_q[XLEN-2:0], 1'b0};
      end
    end else begin
      step_acc = mul_sum[XLEN:1];
      step_quo = {mul_sum[0], quo_q[XLEN-1:1]};
    end

    prod_mag = {acc_q, quo_q};
    prod_it  = neg_q ? -prod_mag : prod_mag;
    quot     = neg_q ? -quo_q : quo_q;
    remv     = negr_q ? -acc_q : acc_q;
    if (op_q[2])                iter_res = op_q[1] ? remv : quot;
    else if (op_q[1:0] == 2'b00) iter_res = prod_it[XLEN-1:0];
    else                         iter_res = prod_it[2*XLEN-1:XLEN];

    fa_sbit   = a_signed(op_q) & rs1_q[XLEN-1];
    fb_sbit   = b_signed(op_q) & rs2_q[XLEN-1];
    fast_prod = {{XLEN{fa_sbit}}, rs1_q} * {{XLEN{fb_sbit}}, rs2_q};
    fast_res  = (op_q[1:0] == 2'b00) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];

    if (is_special(op_q, rs1_q, rs2_q)) res_sel = special_val(op_q, rs1_q, rs2_q);
    else if (FAST_MUL && !op_q[2])      res_sel = fast_res;
    else                                res_sel = iter_res;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    acc_d        = acc_q;
    quo_d        = quo_q;
    dvs_d        = dvs_q;
    neg_d        = neg_q;
    negr_d       = negr_q;
    resp_valid_d = resp_valid_q;
    result_d     = result_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i && req_ready_o) begin
          op_d   = req_op_i;
          rs1_d  = req_rs1_i;
          rs2_d  = req_rs2_i;
          neg_d  = in_a_neg ^ in_b_neg;
          negr_d = in_a_neg;
          cnt_d  = '0;
          acc_d  = '0;
          quo_d  = req_op_i[2] ? in_a_mag : in_b_mag;
          dvs_d  = req_op_i[2] ? in_b_mag : in_a_mag;
          if (is_special(req_op_i, req_rs1_i, req_rs2_i) || (FAST_MUL && !req_op_i[2]))
            state_d = S_DONE;
          else
            state_d = S_CALC;
        end
      end
      S_CALC: begin
        acc_d = step_acc;
        quo_d = step_quo;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(XLEN-1)) state_d = S_DONE;
      end
      S_DONE: begin
        // First DONE cycle registers the result; valid rises one edge after entering DONE.
        if (!resp_valid_q) begin
          resp_valid_d = 1'b1;
          result_d     = res_sel;
        end else if (resp_ready_i) begin
          resp_valid_d = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flush_i) begin
      state_d      = S_IDLE;
      resp_valid_d = 1'b0;
      cnt_d        = '0;
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      op_q         <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      acc_q        <= '0;
      quo_q        <= '0;
      dvs_q        <= '0;
      neg_q        <= 1'b0;
      negr_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      result_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      acc_q        <= acc_d;
      quo_q        <= quo_d;
      dvs_q        <= dvs_d;
      neg_q        <= neg_d;
      negr_q       <= negr_d;
      resp_valid_q <= resp_valid_d;
      result_q     <= result_d;
    end
  end

  assign req_ready_o   = (state_q == S_IDLE) && !flush_i;
  assign resp_valid_o  = resp_valid_q;
  assign resp_result_o = result_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_rv_muldiv_unit.sv
// Bench for rv_muldiv_unit: a fast-multiply and an iterative-multiply instance share stimulus;
// each has its own expected-result queue checked as responses are taken.
module tb_rv_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, flush, resp_ready;
  logic [2:0]  req_op;
  logic [31:0] rs1, rs2;
  logic        f_ready, f_valid, s_ready, s_valid;
  logic [31:0] f_result, s_result;
  logic [1:0]  f_dbg, s_dbg;

  int n_cmp = 0;
  int n_fail = 0;
  logic [31:0] exp_f[$];
  logic [31:0] exp_s[$];

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;
  vec_t tbl[14];

  always #5 clk = ~clk;

  rv_muldiv_unit #(.XLEN(32), .FAST_MUL(1'b1)) u_fast (
    .clk_i(clk), .arstn_i(rst_n), .req_valid_i(req_valid), .req_ready_o(f_ready),
    .req_op_i(req_op), .req_rs1_i(rs1), .req_rs2_i(rs2), .flush_i(flush),
    .resp_valid_o(f_valid), .resp_ready_i(resp_ready), .resp_result_o(f_result),
    .dbg_state_o(f_dbg));

  rv_muldiv_unit #(.XLEN(32), .FAST_MUL(1'b0)) u_slow (
    .clk_i(clk), .arstn_i(rst_n), .req_valid_i(req_valid), .req_ready_o(s_ready),
    .req_op_i(req_op), .req_rs1_i(rs1), .req_rs2_i(rs2), .flush_i(flush),
    .resp_valid_o(s_valid), .resp_ready_i(resp_ready), .resp_result_o(s_result),
    .dbg_state_o(s_dbg));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, ub;
    logic [63:0] p;
    logic ovf;
    sa  = $signed(a);
    sb  = $signed(b);
    ub  = {32'd0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(sa / sb));
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : (ovf ? 32'd0 : 32'(sa % sb));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Scoreboard: a response is taken on the edge after a negedge that sees valid & ready.
  always @(negedge clk) begin
    if (rst_n && !flush && resp_ready) begin
      if (f_valid) begin
        if (exp_f.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL fast_unexpected_resp: actual=%0h required=no response", f_result);
        end else check("fast_result", f_result, exp_f.pop_front());
      end
      if (s_valid) begin
        if (exp_s.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL slow_unexpected_resp: actual=%0h required=no response", s_result);
        end else check("slow_result", s_result, exp_s.pop_front());
      end
    end
  end

  task automatic wait_idle();
    int waitc;
    waitc = 0;
    @(negedge clk);
    while (!(f_ready && s_ready) && waitc < 300) begin
      @(negedge clk);
      waitc++;
    end
    if (waitc >= 300) begin
      n_cmp++; n_fail++;
      $display("FAIL idle_timeout: actual=busy required=idle");
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int exp_lat, input string name);
    int lat;
    wait_idle();
    req_valid = 1'b1; req_op = op; rs1 = a; rs2 = b;
    exp_f.push_back(exp);
    exp_s.push_back(exp);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    @(negedge clk);
    while (!f_valid && lat < 100) begin
      lat++;
      @(negedge clk);
    end
    check({name, "_latency"}, 64'(lat), 64'(exp_lat));
  endtask

  task automatic watch_quiet(input string name);
    logic seen;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (f_valid || s_valid) seen = 1'b1;
    end
    check(name, seen, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    int          lat;

    tbl[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1};
    tbl[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 1};
    tbl[2]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 1};
    tbl[3]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1};
    tbl[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33};
    tbl[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33};
    tbl[6]  = '{3'd5, 32'd100,        32'd7,         32'd14,        33};
    tbl[7]  = '{3'd7, 32'd100,        32'd7,         32'd2,         33};
    tbl[8]  = '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1};
    tbl[9]  = '{3'd6, 32'd5,          32'd0,         32'd5,         1};
    tbl[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
    tbl[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1};
    tbl[12] = '{3'd4, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 33};
    tbl[13] = '{3'd6, 32'd7,          32'hFFFF_FFFE, 32'd1,         33};

    rst_n = 1'b0; req_valid = 1'b0; req_op = '0; rs1 = '0; rs2 = '0;
    flush = 1'b0; resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_valid", f_valid, 0);
    check("reset_result", f_result, 0);
    check("reset_ready", f_ready, 1);
    check("reset_state", f_dbg, 0);
    rst_n = 1'b1;

    // flush in IDLE blocks a request
    @(negedge clk);
    flush = 1'b1; req_valid = 1'b1; req_op = 3'd0; rs1 = 32'd7; rs2 = 32'd3;
    #1 check("flush_ready_low", f_ready, 0);
    @(negedge clk);
    check("flush_no_accept_fast", f_dbg, 0);
    check("flush_no_accept_slow", s_dbg, 0);
    flush = 1'b0; req_valid = 1'b0;

    for (int i = 0; i < 14; i++)
      issue(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].lat, $sformatf("vec%0d", i));

    for (int i = 0; i < 16; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom();
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: begin b = 32'hFFFF_FFFF; if ($urandom_range(0, 1) == 1) a = 32'h8000_0000; end
        2: b = 32'($urandom_range(1, 300));
        default: b = $urandom();
      endcase
      lat = (op[2] && b != 0 && !(!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 33 : 1;
      issue(op, a, b, model(op, a, b), lat, $sformatf("rand%0d", i));
    end

    // backpressure: result held, no accept until the edge after the handshake
    wait_idle();
    resp_ready = 1'b0;
    req_valid = 1'b1; req_op = 3'd5; rs1 = 32'd100; rs2 = 32'd7;
    exp_f.push_back(32'd14);
    exp_s.push_back(32'd14);
    @(posedge clk);
    #1 req_op = 3'd0; rs1 = 32'd3; rs2 = 32'd4;
    lat = 0;
    @(negedge clk);
    while (!f_valid && lat < 100) begin
      lat++;
      @(negedge clk);
    end
    check("bp_latency", 64'(lat), 33);
    repeat (10) begin
      @(negedge clk);
      check("bp_result_stable", f_result, 32'd14);
      check("bp_valid_held", f_valid, 1);
      check("bp_ready_low", f_ready, 0);
    end
    @(posedge clk);
    #1 resp_ready = 1'b1;
    @(posedge clk);
    #1 check("bp_idle_after_handshake", f_dbg, 0);
    check("bp_ready_after_handshake", f_ready, 1);
    exp_f.push_back(32'd12);
    exp_s.push_back(32'd12);
    @(posedge clk);
    #1 check("bp_accept_next_edge", f_dbg, 2);
    req_valid = 1'b0;

    // flush at CALC counter 5
    wait_idle();
    req_valid = 1'b1; req_op = 3'd5; rs1 = 32'd1000; rs2 = 32'd3;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 check("flush_pre_calc", f_dbg, 1);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 check("flush_to_idle", f_dbg, 0);
    check("flush_valid_low", f_valid, 0);
    flush = 1'b0;
    watch_quiet("flush_no_resp");

    // reset at CALC counter 12
    wait_idle();
    req_valid = 1'b1; req_op = 3'd5; rs1 = 32'd1000; rs2 = 32'd3;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1 check("rst_pre_calc", f_dbg, 1);
    #2 rst_n = 1'b0;
    #1 check("rst_state", f_dbg, 0);
    check("rst_valid", f_valid, 0);
    check("rst_result", f_result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    watch_quiet("rst_no_resp");

    issue(3'd5, 32'd9, 32'd3, 32'd3, 33, "fresh_divu");

    wait_idle();
    check("fast_queue_drained", 64'(exp_f.size()), 0);
    check("slow_queue_drained", 64'(exp_s.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
